// File: rtl/unsigned_div_pkg.sv
// Shared types and width constant for the sequential restoring divider.
package unsigned_div_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   r_in,
    input  logic         din,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_out,
    output logic         q_bit
);

    // r_in < divisor on entry, so the top bit of t is always 0; carrying it
    // keeps the compare/subtract exact without relying on that invariant.
    logic [W+1:0] t;
    logic [W+1:0] diff;

    always_comb begin
        t     = {r_in, din};
        q_bit = (t >= {2'b00, divisor});
        diff  = q_bit ? (t - {2'b00, divisor}) : t;
        r_out = (W+1)'(diff);
    end

endmodule

// File: rtl/unsigned_16by8_div_seq.sv
// Iterative 2W-by-W unsigned divider, one quotient bit per clock, valid/ready on both sides.
module unsigned_16by8_div_seq
    import unsigned_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    div_state_t   state_q, state_d;
    logic [W:0]   r_q, r_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         dz_q, dz_d;
    logic         ov_q, ov_d;

    logic [W:0]   step_r;
    logic         step_q;

    div_step #(.W(W)) u_step (
        .r_in    (r_q),
        .din     (lo_q[W-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    lo_d  = dividend[W-1:0];
                    r_d   = {1'b0, dividend[2*W-1:W]};
                    quo_d = '0;
                    dz_d  = 1'b0;
                    ov_d  = 1'b0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        quo_d   = '1;
                        r_d     = {1'b0, dividend[W-1:0]};
                        state_d = DONE;
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        ov_d    = 1'b1;
                        quo_d   = '1;
                        r_d     = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CW'(W - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                r_d   = step_r;
                quo_d = {quo_q[W-2:0], step_q};
                lo_d  = {lo_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            dvs_q   <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            lo_q    <= lo_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = r_q[W-1:0];
    assign div_zero  = dz_q;
    assign ovf       = ov_q;

endmodule

// File: tb/tb_unsigned_16by8_div_seq.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_unsigned_16by8_div_seq;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    exp_t sb[$];

    unsigned_16by8_div_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        if (dvs == 8'd0) begin
            e = '{q: 8'hFF, r: dvd[7:0], dz: 1'b1, ov: 1'b0};
        end else if ((dvd / dvs) > 16'd255) begin
            e = '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b1};
        end else begin
            e = '{q: 8'(dvd / dvs), r: 8'(dvd % dvs), dz: 1'b0, ov: 1'b0};
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every DONE cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {quotient, remainder, div_zero, ovf}, 32'hDEAD);
            end else begin
                chk("result", {7'd0, quotient, remainder, div_zero, ovf, in_ready},
                    {7'd0, sb[0].q, sb[0].r, sb[0].dz, sb[0].ov, 1'b0});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] dvd, input logic [7:0] dvs, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen.
    task automatic wait_valid(output int k);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        logic [15:0] dvd;
        logic [7:0]  dvs;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {quotient, remainder, div_zero, ovf}, 0);
        rst = 1'b0;

        // 65025/255: full 8-step latency
        send(16'd65025, 8'd255, '{q: 8'd255, r: 8'd0, dz: 1'b0, ov: 1'b0});
        wait_valid(k);
        chk("latency_normal", k, 8);

        // 1000/7 held in DONE with junk offered on the input side
        rdy_mode = 2;
        send(16'd1000, 8'd7, '{q: 8'd142, r: 8'd6, dz: 1'b0, ov: 1'b0});
        wait_valid(k);
        chk("latency_1000_7", k, 8);
        in_valid = 1'b1;
        dividend = 16'h0101;
        divisor  = 8'd3;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 0;

        // exceptions resolve on the accept edge
        send(16'h1234, 8'h00, '{q: 8'hFF, r: 8'h34, dz: 1'b1, ov: 1'b0});
        wait_valid(k);
        chk("latency_div_zero", k, 0);
        send(16'h1234, 8'h12, '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b1});
        wait_valid(k);
        chk("latency_ovf", k, 0);
        send(16'h00FF, 8'h01, '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b0});
        send(16'h0100, 8'h01, '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b1});
        send(16'd0, 8'd5, '{q: 8'd0, r: 8'd0, dz: 1'b0, ov: 1'b0});
        send(16'h7FFF, 8'h80, '{q: 8'hFF, r: 8'h7F, dz: 1'b0, ov: 1'b0});

        // reset in the middle of 1000/7
        wait_valid(k);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {quotient, remainder, div_zero, ovf}, 0);
        rst = 1'b0;
        sb.delete();
        send(16'd100, 8'd9, '{q: 8'd11, r: 8'd1, dz: 1'b0, ov: 1'b0});

        // back-to-back random pairs under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            dvd = 16'($urandom);
            dvs = 8'($urandom);
            case ($urandom_range(0, 3))
                0: dvs = 8'd0;
                1: dvd[15:8] = 8'($urandom_range(0, 255)) % (dvs | 8'd1);
                default: ;
            endcase
            send(dvd, dvs, model(dvd, dvs));
        end

        rdy_mode = 0;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
